// File: rtl/ascon_perm_sched.sv
// Iterative ASCON permutation scheduler: one pc -> ps -> pl round per clock.
// Runs p12 / p6 / p8, all ending at LAST_ROUND, with a start/done handshake.

package ascon_perm_pkg;
  // Index 0 is x0, the word that supplies the sbox input MSB.
  typedef logic [4:0][63:0] type_state;
endpackage

// Round-constant addition into the low byte of x2.
module ascon_pc
  import ascon_perm_pkg::*;
(
  input  type_state  state,
  input  logic [3:0] round,
  output type_state  result
);
  logic [3:0] round_inv;

  assign round_inv = 4'hF - round;

  always_comb begin
    result = state;
    result[2][7:0] = state[2][7:0] ^ {round_inv, round};
  end
endmodule

// 5-bit sbox applied to each of the 64 bit columns.
module ascon_ps
  import ascon_perm_pkg::*;
(
  input  type_state state,
  output type_state result
);
  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
    endcase
    return y;
  endfunction

  always_comb begin
    logic [4:0] col_out;
    result  = '0;
    col_out = '0;
    for (int i = 0; i < 64; i++) begin
      col_out = sbox({state[0][i], state[1][i], state[2][i], state[3][i], state[4][i]});
      result[0][i] = col_out[4];
      result[1][i] = col_out[3];
      result[2][i] = col_out[2];
      result[3][i] = col_out[1];
      result[4][i] = col_out[0];
    end
  end
endmodule

// Per-word linear diffusion: x ^= ror(x, a) ^ ror(x, b).
module ascon_pl
  import ascon_perm_pkg::*;
(
  input  type_state state,
  output type_state result
);
  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    logic [127:0] dbl;
    dbl = {x, x} >> n;
    return dbl[63:0];
  endfunction

  always_comb begin
    result    = '0;
    result[0] = state[0] ^ ror(state[0], 19) ^ ror(state[0], 28);
    result[1] = state[1] ^ ror(state[1], 61) ^ ror(state[1], 39);
    result[2] = state[2] ^ ror(state[2],  1) ^ ror(state[2],  6);
    result[3] = state[3] ^ ror(state[3], 10) ^ ror(state[3], 17);
    result[4] = state[4] ^ ror(state[4],  7) ^ ror(state[4], 41);
  end
endmodule

// state | meaning
// IDLE  | waiting for start_i; state register holds last result
// RUN   | one round applied per edge, round_q counts up to LAST_ROUND
// DONE  | result valid for one cycle; start_i here is accepted back-to-back
module ascon_perm_sched
  import ascon_perm_pkg::*;
#(
  parameter logic [3:0] LAST_ROUND = 4'd11,
  parameter logic [3:0] P6_FIRST   = 4'd6,
  parameter logic [3:0] P8_FIRST   = 4'd4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t       fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] first_round;
  type_state  pc_out, ps_out, pl_out;

  ascon_pc u_pc (.state(state_q), .round(round_q), .result(pc_out));
  ascon_ps u_ps (.state(pc_out),  .result(ps_out));
  ascon_pl u_pl (.state(ps_out),  .result(pl_out));

  // Reserved mode 11 falls through to p12.
  always_comb begin
    case (mode_i)
      2'b01:   first_round = P6_FIRST;
      2'b10:   first_round = P8_FIRST;
      default: first_round = 4'd0;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          round_d = first_round;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = pl_out;
        if (round_q == LAST_ROUND) fsm_d = DONE;
        else round_d = round_q + 4'd1;
      end
      DONE: begin
        if (start_i) begin
          state_d = state_i;
          round_d = first_round;
          fsm_d   = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);
endmodule

// File: tb/tb_ascon_perm_sched.sv
// Bench for ascon_perm_sched: transaction-level permutation model plus
// a per-cycle compare of state/round/busy/done.
module tb_ascon_perm_sched;
  import ascon_perm_pkg::*;

  logic       clock_i  = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i  = 1'b0;
  logic [1:0] mode_i   = 2'b00;
  type_state  state_i  = '0;
  type_state  state_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ascon_perm_sched dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .state_i (state_i),
    .state_o (state_o),
    .round_o (round_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clock_i = ~clock_i;

  // Published ASCON round constants for rounds 0..11.
  localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                     8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bit-sliced sbox over whole words.
  function automatic type_state m_sbox(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    return type_state'({x4, x3, x2, x1, x0});
  endfunction

  function automatic type_state m_linear(input type_state s);
    type_state r;
    r[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
    r[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
    r[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    r[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
    r[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
    return r;
  endfunction

  function automatic type_state m_round(input type_state s, input int r);
    type_state t;
    t = s;
    t[2][7:0] = t[2][7:0] ^ RC[r];
    return m_linear(m_sbox(t));
  endfunction

  function automatic int first_of(input logic [1:0] m);
    case (m)
      2'b01:   return 6;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic type_state m_perm(input type_state s, input logic [1:0] m);
    type_state r;
    r = s;
    for (int k = first_of(m); k <= 11; k++) r = m_round(r, k);
    return r;
  endfunction

  function automatic type_state rand_state();
    type_state r;
    for (int k = 0; k < 5; k++) r[k] = {$urandom(), $urandom()};
    return r;
  endfunction

  typedef struct {
    int        rnd;
    bit        busy;
    bit        done;
    type_state st;
  } exp_t;

  exp_t plan[$];
  exp_t cur = '{rnd: 0, busy: 1'b0, done: 1'b0, st: '0};

  // Model: an accepted start schedules every cycle of the run up front.
  initial forever begin
    @(posedge clock_i or negedge resetb_i);
    if (!resetb_i) begin
      plan.delete();
      cur = '{rnd: 0, busy: 1'b0, done: 1'b0, st: '0};
    end else if (!cur.busy && start_i) begin
      exp_t      e;
      type_state s;
      s = state_i;
      for (int r = first_of(mode_i); r <= 11; r++) begin
        e = '{rnd: r, busy: 1'b1, done: 1'b0, st: s};
        plan.push_back(e);
        s = m_round(s, r);
      end
      e = '{rnd: 11, busy: 1'b0, done: 1'b1, st: s};
      plan.push_back(e);
      cur = plan.pop_front();
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else begin
      cur.done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clock_i);
    if (chk_en) begin
      n_checks++;
      if (state_o !== cur.st || round_o !== cur.rnd[3:0] ||
          busy_o !== cur.busy || done_o !== cur.done) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t state_o=%h want=%h round=%0d want=%0d busy=%b want=%b done=%b want=%b",
                 $time, state_o, cur.st, round_o, cur.rnd, busy_o, cur.busy, done_o, cur.done);
      end
    end
  end

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Caller is at negedge+1; returns at negedge+1 with start_i low.
  task automatic go(input logic [1:0] m, input type_state s, input int want_lat, input bit noisy);
    int count;
    type_state golden;
    golden  = m_perm(s, m);
    start_i = 1'b1;
    mode_i  = m;
    state_i = s;
    for (count = 1; count <= 40; count++) begin
      @(negedge clock_i);
      if (count == 2) chk("first_round_state", state_o, m_round(s, first_of(m)));
      if (done_o) break;
      #1;
      if (noisy) begin
        start_i = 1'($urandom_range(0, 1));
        mode_i  = 2'($urandom_range(0, 3));
        state_i = rand_state();
      end else begin
        start_i = 1'b0;
      end
    end
    chk("latency", 320'(count), 320'(want_lat));
    chk("result", state_o, golden);
    #1 start_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    type_state iv, t, u, z;
    int dones, first_done;
    bit found;

    // Pin the model against hand-derived values.
    z = '0;
    z[2] = '1;
    chk("model_sbox_zero", m_sbox('0), z);
    t = '0;
    t[4][0] = 1'b1;
    z = '0;
    z[1][0] = 1'b1; z[3][0] = 1'b1; z[4][0] = 1'b1;
    z[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    chk("model_sbox_col1", m_sbox(t), z);
    t = '0;
    t[2][7:0] = RC[0];
    u = m_sbox(t);
    chk("model_pc_ps_x0", 320'(u[0]), 320'(64'h0000_0000_0000_00F0));
    chk("model_pc_ps_x2", 320'(u[2]), 320'(64'hFFFF_FFFF_FFFF_FF0F));
    u = m_round('0, 0);
    chk("model_r0_x2", 320'(u[2]), 320'(64'h3FFF_FFFF_FFFF_FF74));
    chk("model_r0_x3", 320'(u[3]), 320'(64'h3C78_0000_0000_00F0));
    chk("model_r0_x4", 320'(u[4]), 320'd0);

    repeat (3) @(negedge clock_i);
    chk("reset_state", state_o, 320'd0);
    chk("reset_ctrl", 320'({busy_o, done_o, round_o}), 320'd0);
    #1 resetb_i = 1'b1;
    chk_en = 1'b1;

    iv[0] = 64'h80400C0600000000;
    iv[1] = 64'h0001020304050607;
    iv[2] = 64'h08090A0B0C0D0E0F;
    iv[3] = 64'h0011223344556677;
    iv[4] = 64'h8899AABBCCDDEEFF;

    go(2'b00, iv, 13, 1'b0);
    go(2'b01, iv, 7, 1'b0);
    go(2'b10, iv, 9, 1'b0);
    go(2'b00, '0, 13, 1'b0);
    go(2'b11, iv, 13, 1'b1);
    go(2'b01, rand_state(), 7, 1'b1);
    go(2'b10, rand_state(), 9, 1'b1);
    repeat (2) @(negedge clock_i);
    #1;

    // start_i held high for 20 edges in p6.
    dones = 0;
    first_done = 0;
    start_i = 1'b1;
    mode_i  = 2'b01;
    state_i = rand_state();
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock_i);
      if (done_o) begin
        dones++;
        if (first_done == 0) first_done = k;
      end
      if (k == 20) #1 start_i = 1'b0;
    end
    chk("held_start_dones", 320'(dones), 320'd3);
    chk("held_start_first_done", 320'(first_done), 320'd7);
    #1;

    // Asynchronous reset in the middle of a p12 run.
    found = 1'b0;
    start_i = 1'b1;
    mode_i  = 2'b00;
    state_i = iv;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_i);
      if (busy_o && round_o == 4'd5) begin
        found = 1'b1;
        break;
      end
      #1 start_i = 1'b0;
    end
    start_i = 1'b0;
    chk("reach_round5", 320'(found), 320'd1);
    #2 resetb_i = 1'b0;
    #1;
    chk("midrun_reset_state", state_o, 320'd0);
    chk("midrun_reset_ctrl", 320'({busy_o, done_o, round_o}), 320'd0);
    repeat (2) @(negedge clock_i);
    #1 resetb_i = 1'b1;
    go(2'b00, iv, 13, 1'b0);

    // Random traffic: sparse starts, noisy mode/state every cycle.
    for (int k = 0; k < 400; k++) begin
      start_i = ($urandom_range(0, 4) == 0);
      mode_i  = 2'($urandom_range(0, 3));
      state_i = rand_state();
      @(negedge clock_i);
      #1;
    end
    start_i = 1'b0;
    repeat (20) @(negedge clock_i);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
